digit_counter: RTL and testbench

Upstream stage for the 7-segment decoder: produces the 4-bit hex `digit` that feeds `dec7seg` on the DESim board. The counter can auto-increment or auto-decrement at a prescaled rate, single-step from a push button, or load a value from the switches. It synchronizes and edge-detects the active-low KEY inputs, divides `CLOCK_50` down to a count tick, and flags wrap-around with a one-cycle carry pulse.

---
 rtl/digit_counter.sv | 200 ++++++++++++++++++++
 tb/tb_digit_counter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/digit_counter.sv
// ---------------------------------------------------------------------------
// digit_counter
//
// Produces the 4-bit hex digit that drives the 7-segment decoder. The digit
// can count up or down automatically at a prescaled rate. It can also
// single-step from a push button, or load a value from the switches. A
// one-cycle carry pulse flags each wrap-around.
//
// Parameters
//   CLK_HZ     input clock frequency
//   TICK_HZ    auto-count rate; DIV = CLK_HZ/TICK_HZ must be >= 2
//   DB_CYCLES  debounce stability window in clocks (>= 1). It is only used
//              when DIGIT_COUNTER_DEBOUNCE_EN is defined.
//
// Ports
//   CLOCK_50   the only clock, rising edge
//   reset      asynchronous, active-low reset
//   run        level: 1 = auto-count on each prescaler tick
//   up         level: 1 = count up, 0 = count down
//   load_n     active-low key: a press loads load_val
//   step_n     active-low key: a press steps once while run = 0
//   load_val   value to load
//   digit      current count (registered)
//   carry      one-cycle pulse, coincident with a wrapped digit (registered)
//
// Build option
//   DIGIT_COUNTER_DEBOUNCE_EN  When defined, each synchronized key passes
//                              through a DB_CYCLES stability filter before
//                              edge detection.
// ---------------------------------------------------------------------------
module digit_counter #(
    parameter int CLK_HZ    = 50_000_000,
    parameter int TICK_HZ   = 1,
    parameter int DB_CYCLES = 500_000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       run,
    input  logic       up,
    input  logic       load_n,
    input  logic       step_n,
    input  logic [3:0] load_val,
    output logic [3:0] digit,
    output logic       carry
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

    localparam int KEY_LOAD = 0;
    localparam int KEY_STEP = 1;
    localparam int NKEYS    = 2;

    // -----------------------------------------------------------------------
    // Elaboration-time parameter checks
    // -----------------------------------------------------------------------
    if (DIV < 2) begin : g_bad_div
        $error("digit_counter: CLK_HZ/TICK_HZ must be at least 2");
    end

    if (DB_CYCLES < 1) begin : g_bad_db
        $error("digit_counter: DB_CYCLES must be at least 1");
    end

    // -----------------------------------------------------------------------
    // Key path: 2-flop synchronizer, optional debounce filter, then a
    // previous-value flop for falling-edge (press) detection. Every flop
    // resets to 1 (released), so leaving reset cannot look like a press.
    // -----------------------------------------------------------------------
    logic [NKEYS-1:0] key_raw;
    logic [NKEYS-1:0] key_press;

    assign key_raw[KEY_LOAD] = load_n;
    assign key_raw[KEY_STEP] = step_n;

    for (genvar gi = 0; gi < NKEYS; gi++) begin : g_key
        logic sync1_reg;
        logic sync2_reg;
        logic prev_reg;
        logic level;

        always_ff @(posedge CLOCK_50 or negedge reset) begin
            if (!reset) begin
                sync1_reg <= 1'b1;
                sync2_reg <= 1'b1;
            end else begin
                sync1_reg <= key_raw[gi];
                sync2_reg <= sync1_reg;
            end
        end

`ifdef DIGIT_COUNTER_DEBOUNCE_EN
        localparam int CW = $clog2(DB_CYCLES + 1);
        localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

        logic          filt_reg;
        logic [CW-1:0] cnt_reg;

        // cnt_reg counts consecutive samples that disagree with the filtered
        // level. The level flips on the DB_CYCLES-th sample in a row that
        // disagrees. Any sample that agrees with the level restarts the run.
        always_ff @(posedge CLOCK_50 or negedge reset) begin
            if (!reset) begin
                filt_reg <= 1'b1;
                cnt_reg  <= '0;
            end else if (sync2_reg == filt_reg) begin
                cnt_reg  <= '0;
            end else if (cnt_reg == CNT_LAST) begin
                filt_reg <= sync2_reg;
                cnt_reg  <= '0;
            end else begin
                cnt_reg  <= cnt_reg + 1'b1;
            end
        end

        assign level = filt_reg;
`else
        assign level = sync2_reg;
`endif

        always_ff @(posedge CLOCK_50 or negedge reset) begin
            if (!reset) begin
                prev_reg <= 1'b1;
            end else begin
                prev_reg <= level;
            end
        end

        // A press is a single-cycle event on the falling edge only.
        // Holding the key or releasing it does nothing further.
        assign key_press[gi] = prev_reg & ~level;
    end

    // -----------------------------------------------------------------------
    // Prescaler: counts 0..DIV-1 while run = 1 and is held at 0 while
    // run = 0. A rising run therefore always waits a full DIV cycles.
    // -----------------------------------------------------------------------
    logic [PW-1:0] presc_reg;
    logic [PW-1:0] presc_next;
    logic          tick;

    always_comb begin
        tick       = run && (presc_reg == PRESC_LAST);
        presc_next = presc_reg + 1'b1;
        if (!run || tick) begin
            presc_next = '0;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            presc_reg <= '0;
        end else begin
            presc_reg <= presc_next;
        end
    end

    // -----------------------------------------------------------------------
    // Digit / carry. Priority: load press > count event > hold.
    // A step press is ignored while running. A load never raises carry.
    // -----------------------------------------------------------------------
    logic       count_evt;
    logic [3:0] digit_reg;
    logic [3:0] digit_next;
    logic       carry_reg;
    logic       carry_next;

    assign count_evt = run ? tick : key_press[KEY_STEP];

    always_comb begin
        digit_next = digit_reg;
        carry_next = 1'b0;
        if (key_press[KEY_LOAD]) begin
            digit_next = load_val;
        end else if (count_evt) begin
            if (up) begin
                digit_next = digit_reg + 4'd1;
                carry_next = (digit_reg == 4'hF);
            end else begin
                digit_next = digit_reg - 4'd1;
                carry_next = (digit_reg == 4'h0);
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            digit_reg <= 4'h0;
            carry_reg <= 1'b0;
        end else begin
            digit_reg <= digit_next;
            carry_reg <= carry_next;
        end
    end

    assign digit = digit_reg;
    assign carry = carry_reg;

endmodule

// File: tb/tb_digit_counter.sv
// ---------------------------------------------------------------------------
// tb_digit_counter
//
// Self-checking bench for digit_counter with CLK_HZ=10 and TICK_HZ=1
// (DIV=10). DB_CYCLES=4 takes effect only when DIGIT_COUNTER_DEBOUNCE_EN is
// defined.
//
// A behavioural model predicts digit and carry from the recorded key
// history and the run duration. A single compare process checks the DUT
// against the model on every falling clock edge. It also handles the
// hand-computed literal checks that the directed sequence posts.
// ---------------------------------------------------------------------------
module tb_digit_counter;

    localparam int DIV = 10;
    localparam int DB  = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       run;
    logic       up;
    logic       load_n;
    logic       step_n;
    logic [3:0] load_val;
    logic [3:0] digit;
    logic       carry;

    digit_counter #(
        .CLK_HZ   (10),
        .TICK_HZ  (1),
        .DB_CYCLES(DB)
    ) dut (
        .CLOCK_50(clk),
        .reset   (reset),
        .run     (run),
        .up      (up),
        .load_n  (load_n),
        .step_n  (step_n),
        .load_val(load_val),
        .digit   (digit),
        .carry   (carry)
    );

    always #5 clk = ~clk;

    // -----------------------------------------------------------------------
    // Behavioural model.
    // raw_*: the key input sampled at each rising edge (bit 0 = previous edge).
    // lev_*: the key level seen by the edge detector (bit 0 = L[k-1],
    //        bit 1 = L[k-2]).
    // Without the filter, L[k] is the raw sample from the previous edge.
    // With the filter, L[k] flips only after DB consecutive samples that
    // disagree with it.
    // A press acts at edge k when L[k-2] = 1 and L[k-1] = 0.
    // run_cnt counts consecutive edges at which run was 1. A tick falls on
    // every multiple of DIV.
    // -----------------------------------------------------------------------
    logic [3:0]  m_digit  = 4'h0;
    logic        m_carry  = 1'b0;
    logic [31:0] raw_load = '1;
    logic [31:0] raw_step = '1;
    logic [1:0]  lev_load = 2'b11;
    logic [1:0]  lev_step = 2'b11;
    int          run_cnt  = 0;

    function automatic logic next_level(input logic [31:0] raw, input logic cur);
`ifdef DIGIT_COUNTER_DEBOUNCE_EN
        for (int i = 1; i <= DB; i++) begin
            if (raw[i] == cur) return cur;
        end
        return ~cur;
`else
        return raw[0];
`endif
    endfunction

    always @(posedge clk or negedge reset) begin : model
        logic lp;
        logic sp;
        logic tk;
        int   rc;
        if (!reset) begin
            m_digit  <= 4'h0;
            m_carry  <= 1'b0;
            raw_load <= '1;
            raw_step <= '1;
            lev_load <= 2'b11;
            lev_step <= 2'b11;
            run_cnt  <= 0;
        end else begin
            lp = (lev_load == 2'b10);
            sp = (lev_step == 2'b10);
            rc = run ? run_cnt + 1 : 0;
            tk = run && (rc % DIV == 0);
            m_carry <= 1'b0;
            if (lp) begin
                m_digit <= load_val;
            end else if (run ? tk : sp) begin
                if (up) begin
                    m_digit <= m_digit + 4'd1;
                    m_carry <= (m_digit == 4'hF);
                end else begin
                    m_digit <= m_digit - 4'd1;
                    m_carry <= (m_digit == 4'h0);
                end
            end
            run_cnt  <= rc;
            lev_load <= {lev_load[0], next_level(raw_load, lev_load[0])};
            lev_step <= {lev_step[0], next_level(raw_step, lev_step[0])};
            raw_load <= {raw_load[30:0], load_n};
            raw_step <= {raw_step[30:0], step_n};
        end
    end

    // -----------------------------------------------------------------------
    // Compare process: this is the only writer of the counters.
    // -----------------------------------------------------------------------
    int     nvec = 0;
    int     nmis = 0;
    int     lit_seq = 0;
    int     lit_done = 0;
    string  lit_name;
    logic [3:0] lit_d;
    logic       lit_c;

    always @(negedge clk) begin
        nvec++;
        if (digit !== m_digit || carry !== m_carry) begin
            nmis++;
            $display("FAIL cycle t=%0t: digit=%h carry=%b, model digit=%h carry=%b",
                     $time, digit, carry, m_digit, m_carry);
        end
        if (lit_seq != lit_done) begin
            lit_done = lit_seq;
            nvec++;
            if (digit !== lit_d || carry !== lit_c) begin
                nmis++;
                $display("FAIL %s: digit=%h carry=%b, expected digit=%h carry=%b",
                         lit_name, digit, carry, lit_d, lit_c);
            end else begin
                $display("check %s: digit=%h carry=%b ok", lit_name, digit, carry);
            end
            nvec++;
            if (m_digit !== lit_d || m_carry !== lit_c) begin
                nmis++;
                $display("FAIL model_%s: model digit=%h carry=%b, expected digit=%h carry=%b",
                         lit_name, m_digit, m_carry, lit_d, lit_c);
            end
        end
    end

    // Inputs change 2 time units after a rising edge.
    task automatic step_cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic check_lit(input string name, input logic [3:0] d, input logic c);
        lit_name = name;
        lit_d    = d;
        lit_c    = c;
        lit_seq++;
    endtask

    // -----------------------------------------------------------------------
    // Directed sequence
    // -----------------------------------------------------------------------
    initial begin
        reset    = 1'b0;
        run      = 1'b1;
        up       = 1'b1;
        load_n   = 1'b1;
        step_n   = 1'b1;
        load_val = 4'h0;
        step_cyc(3);
        check_lit("reset_state", 4'h0, 1'b0);

        // Reset release with run=1: first tick 10 edges later, then 20.
        step_cyc(1);
        reset = 1'b1;
        step_cyc(9);
        check_lit("before_first_tick", 4'h0, 1'b0);
        step_cyc(1);
        check_lit("first_tick", 4'h1, 1'b0);
        step_cyc(10);
        check_lit("second_tick", 4'h2, 1'b0);

        // Load F, then auto-count up through the wrap.
        run      = 1'b0;
        load_val = 4'hF;
        load_n   = 1'b0;
        step_cyc(3);
        check_lit("load_F", 4'hF, 1'b0);
        load_n = 1'b1;
        run    = 1'b1;
        step_cyc(9);
        check_lit("pre_wrap", 4'hF, 1'b0);
        step_cyc(1);
        check_lit("up_wrap", 4'h0, 1'b1);
        step_cyc(1);
        check_lit("carry_one_cycle", 4'h0, 1'b0);

        // Down step with the key held for 20 cycles.
        run    = 1'b0;
        up     = 1'b0;
        step_n = 1'b0;
        step_cyc(2);
        check_lit("step_latency", 4'h0, 1'b0);
        step_cyc(1);
        check_lit("down_wrap", 4'hF, 1'b1);
        step_cyc(1);
        check_lit("down_carry_end", 4'hF, 1'b0);
        step_cyc(16);
        check_lit("held_key", 4'hF, 1'b0);
        step_n = 1'b1;
        step_cyc(3);
        check_lit("release", 4'hF, 1'b0);

        // Load/step collision.
        load_val = 4'h3;
        load_n   = 1'b0;
        step_cyc(3);
        check_lit("load_3", 4'h3, 1'b0);
        load_n = 1'b1;
        step_cyc(3);
        up       = 1'b1;
        load_val = 4'h7;
        load_n   = 1'b0;
        step_n   = 1'b0;
        step_cyc(3);
        check_lit("collision", 4'h7, 1'b0);
        step_cyc(1);
        check_lit("collision_hold", 4'h7, 1'b0);
        load_n = 1'b1;
        step_n = 1'b1;
        step_cyc(3);

        // Run gating: drop at prescaler count 5, then raise again.
        run = 1'b1;
        step_cyc(5);
        run = 1'b0;
        step_cyc(7);
        run = 1'b1;
        step_cyc(9);
        check_lit("gate_early", 4'h7, 1'b0);
        step_cyc(1);
        check_lit("gate_tick", 4'h8, 1'b0);

        // A step press while running is discarded.
        step_n = 1'b0;
        step_cyc(5);
        step_n = 1'b1;
        step_cyc(4);
        check_lit("step_discard", 4'h8, 1'b0);
        step_cyc(1);
        check_lit("run_tick", 4'h9, 1'b0);

        run = 1'b0;
`ifdef DIGIT_COUNTER_DEBOUNCE_EN
        // A 2-cycle glitch is filtered. A 6-cycle press steps once, 7 edges
        // after the falling edge.
        step_n = 1'b0;
        step_cyc(2);
        step_n = 1'b1;
        step_cyc(10);
        check_lit("glitch", 4'h9, 1'b0);
        step_n = 1'b0;
        step_cyc(6);
        check_lit("db_early", 4'h9, 1'b0);
        step_n = 1'b1;
        step_cyc(1);
        check_lit("db_step", 4'hA, 1'b0);
        step_cyc(12);
        check_lit("db_once", 4'hA, 1'b0);
`else
        // Without the filter, even a 2-cycle low is one press.
        step_n = 1'b0;
        step_cyc(2);
        step_n = 1'b1;
        step_cyc(1);
        check_lit("short_press", 4'hA, 1'b0);
        step_cyc(8);
        check_lit("short_once", 4'hA, 1'b0);
`endif

        // Asynchronous reset mid-run, then the first tick DIV edges later.
        run = 1'b1;
        step_cyc(4);
        reset = 1'b0;
        check_lit("async_reset", 4'h0, 1'b0);
        step_cyc(2);
        reset = 1'b1;
        step_cyc(9);
        check_lit("post_reset_wait", 4'h0, 1'b0);
        step_cyc(1);
        check_lit("post_reset_tick", 4'h1, 1'b0);

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
